// File: rtl/aq_idu_id_wbt_dep.sv
// ID-stage consumer of the integer write-back table: checks up to three source
// operands, issues or stalls the decoded instruction, and counts stall cycles.
module aq_idu_id_wbt_dep #(
  parameter int ENTRY_NUM = 32,
  parameter int ENTRY_W   = 7,
  parameter int PERF_W    = 16
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst_b,
  input  logic [ENTRY_NUM*ENTRY_W-1:0] wbt_read_data,
  input  logic                         id_inst_vld,
  input  logic                         id_src0_vld,
  input  logic                         id_src1_vld,
  input  logic                         id_src2_vld,
  input  logic [4:0]                   id_src0_reg,
  input  logic [4:0]                   id_src1_reg,
  input  logic [4:0]                   id_src2_reg,
  input  logic                         is_idu_ready,
  input  logic                         iu_yy_xx_cancel,
  input  logic                         rtu_idu_flush_wbt,
  input  logic                         perf_clr,
  output logic                         idu_dep_issue,
  output logic                         idu_dep_stall,
  output logic [2:0]                   idu_dep_wait_mask,
  output logic                         idu_dep_long_lat,
  output logic [PERF_W-1:0]            idu_dep_stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // state_q is the FSM state register; checkers can bind to it directly.
  state_t          state_q, state_d;
  logic [2:0]      lat_vld_q, lat_vld_d;
  logic [2:0][4:0] lat_reg_q, lat_reg_d;

  logic [ENTRY_W-1:0] entry_a [ENTRY_NUM];
  logic [2:0]         src_vld;
  logic [2:0][4:0]    src_reg;
  logic [2:0]         src_rdy;
  logic [2:0]         src_long;
  logic               all_rdy;
  logic               active;
  logic               kill;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
    assign entry_a[i] = wbt_read_data[i*ENTRY_W +: ENTRY_W];
  end

  // While waiting, the latched operands are authoritative; ID inputs are ignored.
  always_comb begin
    src_vld = 3'b000;
    src_reg = '0;
    if (state_q == WAIT) begin
      src_vld = lat_vld_q;
      src_reg = lat_reg_q;
    end else begin
      src_vld = {id_src2_vld, id_src1_vld, id_src0_vld};
      src_reg = {id_src2_reg, id_src1_reg, id_src0_reg};
    end
  end

  // x0 never waits; VLD already folds in a same-cycle final writeback.
  always_comb begin
    src_rdy  = 3'b000;
    src_long = 3'b000;
    for (int k = 0; k < 3; k++) begin
      src_rdy[k]  = !src_vld[k] || (src_reg[k] == 5'd0) || entry_a[src_reg[k]][6];
      src_long[k] = entry_a[src_reg[k]][4];
    end
  end

  assign all_rdy = &src_rdy;
  assign kill    = rtu_idu_flush_wbt | iu_yy_xx_cancel;
  assign active  = ((state_q == IDLE) && id_inst_vld) || (state_q == WAIT);

  assign idu_dep_issue = active && all_rdy && is_idu_ready && !kill;
  assign idu_dep_stall = active && !all_rdy && !kill;

  always_comb begin
    state_d   = state_q;
    lat_vld_d = lat_vld_q;
    lat_reg_d = lat_reg_q;
    if (kill) begin
      state_d   = IDLE;
      lat_vld_d = 3'b000;
      lat_reg_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (id_inst_vld && !all_rdy) begin
            state_d   = WAIT;
            lat_vld_d = {id_src2_vld, id_src1_vld, id_src0_vld};
            lat_reg_d = {id_src2_reg, id_src1_reg, id_src0_reg};
          end
        end
        WAIT: begin
          if (all_rdy && is_idu_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= IDLE;
      lat_vld_q <= 3'b000;
      lat_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_vld_q <= lat_vld_d;
      lat_reg_q <= lat_reg_d;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      idu_dep_wait_mask <= 3'b000;
      idu_dep_long_lat  <= 1'b0;
    end else if (idu_dep_stall) begin
      idu_dep_wait_mask <= ~src_rdy;
      idu_dep_long_lat  <= |(~src_rdy & src_long);
    end else begin
      idu_dep_wait_mask <= 3'b000;
      idu_dep_long_lat  <= 1'b0;
    end
  end

  // Saturating counter; a clear request beats a same-cycle increment.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      idu_dep_stall_cnt <= '0;
    end else if (perf_clr) begin
      idu_dep_stall_cnt <= '0;
    end else if (idu_dep_stall && (idu_dep_stall_cnt != {PERF_W{1'b1}})) begin
      idu_dep_stall_cnt <= idu_dep_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aq_idu_id_wbt_dep.sv
// Directed bench for aq_idu_id_wbt_dep: issue/stall decisions, latched operands,
// flush/cancel, back-pressure hold and stall counter saturation/clear.
module tb_aq_idu_id_wbt_dep;

  localparam int ENTRY_NUM = 32;
  localparam int ENTRY_W   = 7;
  localparam int PERF_W    = 16;

  localparam logic [6:0] E_RDY  = 7'h40;        // VLD=1
  localparam logic [6:0] E_LONG = 7'b0_0_100_01; // not written back, long-latency producer
  localparam logic [6:0] E_NRDY = 7'h00;        // VLD=0

  logic                         clk;
  logic                         rst_n;
  logic [ENTRY_NUM*ENTRY_W-1:0] wbt;
  logic                         inst_vld;
  logic                         s0_vld, s1_vld, s2_vld;
  logic [4:0]                   s0_reg, s1_reg, s2_reg;
  logic                         ready;
  logic                         cancel;
  logic                         flush;
  logic                         clr;
  logic                         issue;
  logic                         stall;
  logic [2:0]                   wait_mask;
  logic                         long_lat;
  logic [PERF_W-1:0]            stall_cnt;

  int n_vec;
  int n_err;

  aq_idu_id_wbt_dep #(
    .ENTRY_NUM(ENTRY_NUM),
    .ENTRY_W  (ENTRY_W),
    .PERF_W   (PERF_W)
  ) dut (
    .forever_cpuclk   (clk),
    .cpurst_b         (rst_n),
    .wbt_read_data    (wbt),
    .id_inst_vld      (inst_vld),
    .id_src0_vld      (s0_vld),
    .id_src1_vld      (s1_vld),
    .id_src2_vld      (s2_vld),
    .id_src0_reg      (s0_reg),
    .id_src1_reg      (s1_reg),
    .id_src2_reg      (s2_reg),
    .is_idu_ready     (ready),
    .iu_yy_xx_cancel  (cancel),
    .rtu_idu_flush_wbt(flush),
    .perf_clr         (clr),
    .idu_dep_issue    (issue),
    .idu_dep_stall    (stall),
    .idu_dep_wait_mask(wait_mask),
    .idu_dep_long_lat (long_lat),
    .idu_dep_stall_cnt(stall_cnt)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int idx, input logic [6:0] val);
    wbt[idx*ENTRY_W +: ENTRY_W] = val;
  endtask

  task automatic set_inst(input logic v,
                          input logic v0, input logic [4:0] r0,
                          input logic v1, input logic [4:0] r1,
                          input logic v2, input logic [4:0] r2);
    inst_vld = v;
    s0_vld = v0; s0_reg = r0;
    s1_vld = v1; s1_reg = r1;
    s2_vld = v2; s2_reg = r2;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) set_entry(i, E_RDY);
    inst_vld = 1'b0;
    s0_vld = 1'b0; s1_vld = 1'b0; s2_vld = 1'b0;
    s0_reg = 5'd0; s1_reg = 5'd0; s2_reg = 5'd0;
    ready = 1'b1; cancel = 1'b0; flush = 1'b0; clr = 1'b0;

    // Reset state
    #3;
    chk("rst_issue", issue, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mask", wait_mask, 0);
    chk("rst_long", long_lat, 0);
    chk("rst_cnt", stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // All three sources ready -> immediate issue
    set_inst(1, 1, 5'd1, 1, 5'd2, 1, 5'd3);
    chk("rdy_issue", issue, 1);
    chk("rdy_stall", stall, 0);
    tick();
    chk("rdy_mask", wait_mask, 0);
    chk("rdy_cnt", stall_cnt, 0);

    // x0 not written back is ignored; invalid src2 pointing at a busy reg is ignored
    set_entry(0, E_NRDY);
    set_entry(5, E_LONG);
    set_inst(1, 1, 5'd0, 1, 5'd1, 0, 5'd5);
    chk("x0_issue", issue, 1);
    chk("x0_stall", stall, 0);
    tick();
    chk("x0_cnt", stall_cnt, 0);

    // src1 = x5 waits on a long-latency producer; VLD rises in cycle 3
    set_inst(1, 1, 5'd1, 1, 5'd5, 0, 5'd0);
    chk("dep_c0_stall", stall, 1);
    chk("dep_c0_issue", issue, 0);
    tick();
    chk("dep_c1_mask", wait_mask, 3'b010);
    chk("dep_c1_long", long_lat, 1);
    // ID now presents ready registers; latched x5 must still hold the stall
    set_inst(1, 1, 5'd1, 1, 5'd2, 0, 5'd0);
    chk("dep_c1_latched_stall", stall, 1);
    tick();
    chk("dep_c2_mask", wait_mask, 3'b010);
    set_inst(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    chk("dep_c2_noinst_stall", stall, 1);
    tick();
    chk("dep_c3_mask", wait_mask, 3'b010);
    chk("dep_c3_long", long_lat, 1);
    set_entry(5, E_RDY);
    #1;
    chk("dep_c3_issue", issue, 1);
    chk("dep_c3_stall", stall, 0);
    tick();
    chk("dep_c4_mask", wait_mask, 0);
    chk("dep_c4_long", long_lat, 0);
    chk("dep_cnt", stall_cnt, 3);
    chk("dep_idle_noinst", issue, 0);

    // Flush while waiting: outputs forced low, counter kept, back to IDLE
    set_entry(5, E_LONG);
    set_inst(1, 0, 5'd0, 1, 5'd5, 0, 5'd0);
    chk("fl_c0_stall", stall, 1);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 0);
    chk("fl_issue", issue, 0);
    tick();
    flush = 1'b0;
    set_inst(0, 0, 5'd0, 1, 5'd5, 0, 5'd0);
    chk("fl_mask", wait_mask, 0);
    chk("fl_long", long_lat, 0);
    chk("fl_cnt", stall_cnt, 4);
    chk("fl_idle_stall", stall, 0);

    // Back-pressure with operands ready: neither issue nor stall, WAIT held
    set_inst(1, 0, 5'd0, 1, 5'd5, 0, 5'd0);
    chk("bp_c0_stall", stall, 1);
    tick();
    set_entry(5, E_RDY);
    ready = 1'b0;
    #1;
    chk("bp_issue", issue, 0);
    chk("bp_stall", stall, 0);
    tick();
    chk("bp_mask", wait_mask, 0);
    chk("bp_cnt", stall_cnt, 5);
    set_inst(0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    ready = 1'b1;
    #1;
    chk("bp_wait_issue", issue, 1);
    tick();
    chk("bp_after_issue", issue, 0);

    // Clear, then drive the counter to all-ones and check saturation
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cnt", stall_cnt, 0);
    set_entry(5, E_NRDY);
    set_inst(1, 0, 5'd0, 0, 5'd0, 1, 5'd5);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    chk("sat_mask", wait_mask, 3'b100);
    chk("sat_long", long_lat, 0);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    clr = 1'b1;
    #1;
    chk("sat_clr_stall", stall, 1);
    tick();
    clr = 1'b0;
    chk("sat_clr_cnt", stall_cnt, 0);

    // Cancel while stalling: no increment that cycle, back to IDLE
    cancel = 1'b1;
    #1;
    chk("cn_stall", stall, 0);
    tick();
    cancel = 1'b0;
    set_inst(0, 0, 5'd0, 0, 5'd0, 1, 5'd5);
    chk("cn_cnt", stall_cnt, 0);
    chk("cn_mask", wait_mask, 0);
    chk("cn_idle_stall", stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aq_idu_id_wbt_dep.md
Name: aq_idu_id_wbt_dep

Overview:
- Consumer-side reader of the integer write-back table (WBT) in the ID stage.
- For each decoded instruction, reads the WBT entry of up to three source registers and decides whether the instruction may issue or must stall.
- While stalled, holds the dependency state in a small FSM.
- Exports a stall-cycle performance counter and a long-latency-wait hint for clock gating.

Parameters:
- ENTRY_NUM, 32, number of WBT entries (one per integer register; entry 0 = x0).
- ENTRY_W, 7, width of one entry read word.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- forever_cpuclk  input  1  block clock.
- cpurst_b  input  1  asynchronous active-low reset.
- wbt_read_data  input  ENTRY_NUM*ENTRY_W  flattened entry words; entry i at [7i+6:7i].
  - Field [6] VLD: written back, or last producer writing back this cycle.
  - Field [5] WB_CNT2.
  - Field [4:2] producer type.
  - Field [1:0] outstanding count.
- id_inst_vld  input  1  decoded instruction present in ID.
- id_src0_vld / id_src1_vld / id_src2_vld  input  1 each  source used.
- id_src0_reg / id_src1_reg / id_src2_reg  input  5 each  source register index.
- is_idu_ready  input  1  issue stage accepts this cycle.
- iu_yy_xx_cancel  input  1  pipeline cancel.
- rtu_idu_flush_wbt  input  1  flush.
- perf_clr  input  1  clear stall counter.
- idu_dep_issue  output  1  instruction issues this cycle.
- idu_dep_stall  output  1  instruction held for operand dependency.
- idu_dep_wait_mask  output  3  registered, per-source still-waiting flags.
- idu_dep_long_lat  output  1  registered; some waited-on producer has type[2]=1.
- idu_dep_stall_cnt  output  PERF_W  saturating stall-cycle count.

Behaviour:
- Source readiness:
  - src_rdy[k] = !src_vld[k] | (reg==0) | entry[reg][6].
  - WB_CNT2 and a nonzero cnt without VLD mean not ready.
  - all_rdy = &src_rdy.
- Source selection:
  - In IDLE, sources come from the id_src* inputs.
  - In WAIT, sources come from latched valid bits and indices; id_src* inputs are don't-care.
- FSM, 2 states, reset = IDLE:
  - IDLE: when id_inst_vld & !all_rdy, latch the three valid/index pairs and go to WAIT.
  - IDLE: when id_inst_vld & all_rdy, stay in IDLE.
  - WAIT: when all_rdy & is_idu_ready, go to IDLE; otherwise stay.
  - WAIT does not require id_inst_vld, because ID holds the instruction.
- Combinational outputs:
  - idu_dep_issue = (IDLE & id_inst_vld | WAIT) & all_rdy & is_idu_ready.
  - idu_dep_stall = (IDLE & id_inst_vld | WAIT) & !all_rdy.
  - Not ready downstream with all_rdy: neither stall nor issue, and state is held.
- Registered outputs:
  - idu_dep_wait_mask <= ~src_rdy (with sources masked by valid) while stalling, else 0.
  - idu_dep_long_lat <= OR over waiting sources of type[2] while stalling, else 0.
- Stall counter:
  - Increments each cycle idu_dep_stall=1.
  - Saturates at all-ones, no wrap.
  - perf_clr has priority over increment; counter becomes 0.
- Flush/cancel (rtu_idu_flush_wbt | iu_yy_xx_cancel):
  - Next state is IDLE; latches, wait_mask and long_lat clear.
  - issue and stall are forced 0 in that cycle.
  - The stall counter is not incremented in that cycle and is not cleared.
- Reset values: state IDLE, latches 0, wait_mask 0, long_lat 0, stall_cnt 0.
  - idu_dep_issue and idu_dep_stall are 0 since id_inst_vld is expected low.
- Same-cycle writeback: VLD already includes the last producer's writeback, so the consumer issues in that cycle (zero bubble).
- Latency: one-cycle decision. The wait mask is visible one cycle after the stall starts.

Test Plan:
- All three sources ready (their entries have VLD=1), id_inst_vld=1, is_idu_ready=1 -> idu_dep_issue=1, idu_dep_stall=0, state stays IDLE, stall_cnt=0.
- src1=x5 with entry5 VLD=0, cnt=1, type=3'b100; VLD rises at cycle 3 -> stall=1 for cycles 0-2 and issue=1 at cycle 3.
  - wait_mask=3'b010 and long_lat=1 during cycles 1-3.
  - stall_cnt=3.
- src0=x0 with entry0 VLD=0 -> x0 is ignored and the instruction issues immediately.
- In WAIT, change id_src* to ready registers -> still stalls, because the latched indices are used.
- In WAIT, assert rtu_idu_flush_wbt -> stall=0 in the same cycle; next cycle state IDLE, wait_mask=0; stall_cnt keeps its prior value.
- Preload stall_cnt to 16'hFFFE and stall 3 cycles -> counter reaches 16'hFFFF and holds; perf_clr together with a stall -> counter=0.
